hpdcache_cmo_dir_responder: RTL and testbench

//   Directory-side responder for the CMO handler's check/invalidate interface. Holds per-set, per-way

---
 rtl/hpdcache_cmo_dir_responder.sv | 120 ++++++++++++
 tb/tb_hpdcache_cmo_dir_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_cmo_dir_responder.sv
// Directory valid/tag store answering CMO check lookups and invalidations, plus miss-path fills.
// Latency: check result registered, visible 1 cycle after dir_check_i; inval/fill take effect at next edge.
// Backpressure: fill_ready_o low during the post-reset init sweep and whenever an invalidation is presented.
module hpdcache_cmo_dir_responder #(
   parameter int unsigned SETS      = 64,
   parameter int unsigned WAYS      = 4,
   parameter int unsigned TAG_WIDTH = 20,
   parameter int unsigned SET_W     = $clog2(SETS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 init_done_o,
   input  logic                 dir_check_i,
   input  logic [SET_W-1:0]     dir_check_set_i,
   input  logic [TAG_WIDTH-1:0] dir_check_tag_i,
   output logic [WAYS-1:0]      dir_check_hit_way_o,
   input  logic                 dir_inval_i,
   input  logic [SET_W-1:0]     dir_inval_set_i,
   input  logic [WAYS-1:0]      dir_inval_way_i,
   input  logic                 fill_valid_i,
   output logic                 fill_ready_o,
   input  logic [SET_W-1:0]     fill_set_i,
   input  logic [WAYS-1:0]      fill_way_i,
   input  logic [TAG_WIDTH-1:0] fill_tag_i
);

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [SET_W-1:0]     cnt_q, cnt_d;
   logic [WAYS-1:0]      hit_q, hit_d;

   // Directory storage; valid bits are cleared by the init sweep, tags are never reset.
   logic [WAYS-1:0]      valid_q [SETS];
   logic [WAYS-1:0]      valid_d [SETS];
   logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
   logic [TAG_WIDTH-1:0] tag_d   [SETS][WAYS];

   logic fill_fire;

   assign init_done_o         = (state_q == READY);
   assign fill_ready_o        = init_done_o & ~dir_inval_i;
   assign fill_fire           = fill_valid_i & fill_ready_o;
   assign dir_check_hit_way_o = hit_q;

   // Next-state: init sweep, registered lookup (reads pre-update state), inval then fill updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hit_d   = hit_q;
      valid_d = valid_q;
      tag_d   = tag_q;

      case (state_q)
         INIT: begin
            valid_d[cnt_q] = '0;
            if (cnt_q == SET_W'(SETS - 1)) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         READY: begin
            if (dir_check_i) begin
               for (int w = 0; w < WAYS; w++) begin
                  hit_d[w] = valid_q[dir_check_set_i][w] &
                             (tag_q[dir_check_set_i][w] == dir_check_tag_i);
               end
            end
            if (dir_inval_i) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (dir_inval_way_i[w]) begin
                     valid_d[dir_inval_set_i][w] = 1'b0;
                  end
               end
            end
            // A fill can never coincide with an inval: ready is dropped while inval is high.
            if (fill_fire) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (fill_way_i[w]) begin
                     valid_d[fill_set_i][w] = 1'b1;
                     tag_d[fill_set_i][w]   = fill_tag_i;
                  end
               end
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Control state with asynchronous reset back into the sweep.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= INIT;
         cnt_q   <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hit_q   <= hit_d;
      end
   end

   // Storage arrays carry no reset; the sweep establishes a clean valid state.
   always_ff @(posedge clk_i) begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
   end

   // A fill must target exactly one way.
   fill_way_onehot_a : assert property (@(posedge clk_i) disable iff (rst_i)
      fill_valid_i |-> $onehot(fill_way_i))
      else $error("fill_way_i not one-hot: %b", fill_way_i);

endmodule

// File: tb/tb_hpdcache_cmo_dir_responder.sv
module tb_hpdcache_cmo_dir_responder;

   localparam int SETS      = 64;
   localparam int WAYS      = 4;
   localparam int TAG_WIDTH = 20;
   localparam int SET_W     = 6;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 init_done_o;
   logic                 dir_check_i = 1'b0;
   logic [SET_W-1:0]     dir_check_set_i = '0;
   logic [TAG_WIDTH-1:0] dir_check_tag_i = '0;
   logic [WAYS-1:0]      dir_check_hit_way_o;
   logic                 dir_inval_i = 1'b0;
   logic [SET_W-1:0]     dir_inval_set_i = '0;
   logic [WAYS-1:0]      dir_inval_way_i = '0;
   logic                 fill_valid_i = 1'b0;
   logic                 fill_ready_o;
   logic [SET_W-1:0]     fill_set_i = '0;
   logic [WAYS-1:0]      fill_way_i = 4'b0001;
   logic [TAG_WIDTH-1:0] fill_tag_i = '0;

   int checks = 0;
   int errors = 0;

   hpdcache_cmo_dir_responder #(
      .SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TAG_WIDTH)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .init_done_o(init_done_o),
      .dir_check_i(dir_check_i),
      .dir_check_set_i(dir_check_set_i),
      .dir_check_tag_i(dir_check_tag_i),
      .dir_check_hit_way_o(dir_check_hit_way_o),
      .dir_inval_i(dir_inval_i),
      .dir_inval_set_i(dir_inval_set_i),
      .dir_inval_way_i(dir_inval_way_i),
      .fill_valid_i(fill_valid_i),
      .fill_ready_o(fill_ready_o),
      .fill_set_i(fill_set_i),
      .fill_way_i(fill_way_i),
      .fill_tag_i(fill_tag_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_fill(input logic [SET_W-1:0] s, input logic [WAYS-1:0] w,
                          input logic [TAG_WIDTH-1:0] t);
      fill_valid_i = 1'b1;
      fill_set_i   = s;
      fill_way_i   = w;
      fill_tag_i   = t;
      tick();
      fill_valid_i = 1'b0;
   endtask

   task automatic do_check(input logic [SET_W-1:0] s, input logic [TAG_WIDTH-1:0] t);
      dir_check_i     = 1'b1;
      dir_check_set_i = s;
      dir_check_tag_i = t;
      tick();
      dir_check_i = 1'b0;
   endtask

   task automatic do_inval(input logic [SET_W-1:0] s, input logic [WAYS-1:0] w);
      dir_inval_i     = 1'b1;
      dir_inval_set_i = s;
      dir_inval_way_i = w;
      tick();
      dir_inval_i = 1'b0;
   endtask

   // Release reset and verify init_done rises exactly SETS edges later with fill held off.
   task automatic release_and_sweep(input string name);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int i = 1; i <= SETS; i++) begin
         tick();
         if (i >= SETS - 1) begin
            chk({name, "_init_done"}, 32'(init_done_o), 32'(i == SETS));
         end else if (init_done_o !== 1'b0) begin
            chk({name, "_init_done_early"}, 32'(init_done_o), 32'd0);
         end
         if (i < SETS && fill_ready_o !== 1'b0) begin
            chk({name, "_fill_ready_in_init"}, 32'(fill_ready_o), 32'd0);
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_hit", 32'(dir_check_hit_way_o), 32'h0);
      chk("rst_init_done", 32'(init_done_o), 32'h0);
      chk("rst_fill_ready", 32'(fill_ready_o), 32'h0);

      // Sweep with a fill request and check/inval strobes pending: all ignored
      fill_valid_i = 1'b1;
      fill_set_i   = 6'd0;
      fill_way_i   = 4'b0001;
      fill_tag_i   = 20'h0;
      dir_check_i  = 1'b1;
      release_and_sweep("sweep1");
      chk("sweep1_fill_ready_after", 32'(fill_ready_o), 32'h1);
      chk("sweep1_hit_stays_0", 32'(dir_check_hit_way_o), 32'h0);
      fill_valid_i = 1'b0;
      dir_check_i  = 1'b0;

      // Basic fill / hit / miss with 1-cycle latency
      do_fill(6'd5, 4'b0010, 20'hABCDE);
      dir_check_i     = 1'b1;
      dir_check_set_i = 6'd5;
      dir_check_tag_i = 20'hABCDE;
      #1;
      chk("hit_before_edge", 32'(dir_check_hit_way_o), 32'h0);
      tick();
      dir_check_i = 1'b0;
      chk("hit_set5_way1", 32'(dir_check_hit_way_o), 32'h2);
      do_check(6'd5, 20'h12345);
      chk("miss_set5_wrong_tag", 32'(dir_check_hit_way_o), 32'h0);

      // All four ways, partial invalidation
      do_fill(6'd5, 4'b0001, 20'h11111);
      do_fill(6'd5, 4'b0010, 20'h11111);
      do_fill(6'd5, 4'b0100, 20'h11111);
      do_fill(6'd5, 4'b1000, 20'h11111);
      do_check(6'd5, 20'h11111);
      chk("hit_set5_all", 32'(dir_check_hit_way_o), 32'hF);
      dir_inval_i     = 1'b1;
      dir_inval_set_i = 6'd5;
      dir_inval_way_i = 4'b1010;
      #1;
      chk("fill_ready_during_inval", 32'(fill_ready_o), 32'h0);
      tick();
      dir_inval_i = 1'b0;
      chk("hit_holds_after_inval", 32'(dir_check_hit_way_o), 32'hF);
      do_check(6'd5, 20'h11111);
      chk("hit_set5_after_inval", 32'(dir_check_hit_way_o), 32'h5);

      // Last set boundary
      do_fill(6'd63, 4'b1000, 20'h3F3F3);
      do_check(6'd63, 20'h3F3F3);
      chk("hit_set63_way3", 32'(dir_check_hit_way_o), 32'h8);

      // Check + inval same cycle: lookup sees pre-inval state
      do_fill(6'd9, 4'b0001, 20'h99999);
      dir_check_i     = 1'b1;
      dir_check_set_i = 6'd9;
      dir_check_tag_i = 20'h99999;
      dir_inval_i     = 1'b1;
      dir_inval_set_i = 6'd9;
      dir_inval_way_i = 4'b0001;
      tick();
      dir_check_i = 1'b0;
      dir_inval_i = 1'b0;
      chk("check_inval_same_cycle", 32'(dir_check_hit_way_o), 32'h1);
      do_check(6'd9, 20'h99999);
      chk("recheck_set9", 32'(dir_check_hit_way_o), 32'h0);

      // Check + fill same cycle: lookup sees pre-fill state
      fill_valid_i    = 1'b1;
      fill_set_i      = 6'd10;
      fill_way_i      = 4'b0100;
      fill_tag_i      = 20'hAAAAA;
      dir_check_i     = 1'b1;
      dir_check_set_i = 6'd10;
      dir_check_tag_i = 20'hAAAAA;
      tick();
      fill_valid_i = 1'b0;
      dir_check_i  = 1'b0;
      chk("check_fill_same_cycle", 32'(dir_check_hit_way_o), 32'h0);
      do_check(6'd10, 20'hAAAAA);
      chk("recheck_set10", 32'(dir_check_hit_way_o), 32'h4);

      // Inval-all sweep with a fill held pending: fill never accepted
      fill_valid_i = 1'b1;
      fill_set_i   = 6'd0;
      fill_way_i   = 4'b0001;
      fill_tag_i   = 20'h55555;
      for (int s = 0; s < SETS; s++) begin
         dir_inval_i     = 1'b1;
         dir_inval_set_i = 6'(s);
         dir_inval_way_i = 4'b1111;
         #1;
         if (fill_ready_o !== 1'b0 || s == SETS - 1) begin
            chk("inval_sweep_fill_ready", 32'(fill_ready_o), 32'h0);
         end
         tick();
      end
      dir_inval_i  = 1'b0;
      fill_valid_i = 1'b0;
      do_check(6'd5, 20'h11111);
      chk("after_sweep_set5", 32'(dir_check_hit_way_o), 32'h0);
      do_check(6'd10, 20'hAAAAA);
      chk("after_sweep_set10", 32'(dir_check_hit_way_o), 32'h0);
      do_check(6'd63, 20'h3F3F3);
      chk("after_sweep_set63", 32'(dir_check_hit_way_o), 32'h0);
      do_check(6'd0, 20'h55555);
      chk("after_sweep_set0_stalled_fill", 32'(dir_check_hit_way_o), 32'h0);

      // Inval with empty way vector is a no-op
      do_fill(6'd20, 4'b0100, 20'h20202);
      do_fill(6'd33, 4'b0010, 20'h33333);
      do_inval(6'd20, 4'b0000);
      do_check(6'd20, 20'h20202);
      chk("inval_noop_set20", 32'(dir_check_hit_way_o), 32'h4);

      // Async reset in READY with valid lines
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_ready_hit", 32'(dir_check_hit_way_o), 32'h0);
      chk("rst_ready_init_done", 32'(init_done_o), 32'h0);
      chk("rst_ready_fill_ready", 32'(fill_ready_o), 32'h0);

      // Partial sweep of 30 sets, then async reset mid-sweep
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      repeat (30) tick();
      chk("mid_sweep_init_done", 32'(init_done_o), 32'h0);
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_mid_sweep_init_done", 32'(init_done_o), 32'h0);

      // Sweep must restart from set 0 and take the full SETS cycles
      release_and_sweep("sweep2");
      do_check(6'd20, 20'h20202);
      chk("after_reset_set20", 32'(dir_check_hit_way_o), 32'h0);
      do_check(6'd33, 20'h33333);
      chk("after_reset_set33", 32'(dir_check_hit_way_o), 32'h0);
      do_fill(6'd33, 4'b1000, 20'h33333);
      do_check(6'd33, 20'h33333);
      chk("refill_set33", 32'(dir_check_hit_way_o), 32'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
